// File: rtl/fetch_pc_predictor_pkg.sv
// rtl/fetch_pc_predictor_pkg.sv - shared defaults, counter helpers and BTB entry layout
package fetch_pc_predictor_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned CTR_BITS    = 2;

  // Counter encodings: the upper half of the range means "predict taken".
  localparam int unsigned CTR_MAX     = (1 << CTR_BITS) - 1;
  localparam int unsigned CTR_WEAK_T  = 1 << (CTR_BITS - 1);
  localparam int unsigned CTR_WEAK_NT = CTR_WEAK_T - 1;

  function automatic int unsigned ctr_max(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

  function automatic int unsigned ctr_weak_t(input int unsigned bits);
    return 1 << (bits - 1);
  endfunction

  // Entry layout at the default widths; the table builds the same shape at its own widths.
  typedef struct packed {
    logic                                 valid;
    logic                                 is_jump;
    logic [CTR_BITS-1:0]                  ctr;
    logic [WORD_SIZE-$clog2(BTB_ENTRIES)-1:0] tag;
    logic [WORD_SIZE-1:0]                 target;
  } btb_entry_t;

endpackage

// File: rtl/fetch_pc_predictor_if.sv
// rtl/fetch_pc_predictor_if.sv - redirect, update and prediction signals between pipeline and fetch PC
interface fetch_pc_predictor_if #(
  parameter int unsigned WORD_SIZE = fetch_pc_predictor_pkg::WORD_SIZE
);
  logic                 stall;
  logic                 br_redirect;
  logic [WORD_SIZE-1:0] br_redirect_pc;
  logic                 jmp_redirect;
  logic [WORD_SIZE-1:0] jmp_redirect_pc;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic                 upd_is_jump;
  logic                 upd_taken;
  logic [WORD_SIZE-1:0] upd_target;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_next_seq;
  logic                 pred_taken;
  logic [WORD_SIZE-1:0] pred_target;

  modport master (
    output stall, br_redirect, br_redirect_pc, jmp_redirect, jmp_redirect_pc,
           upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    input  pc, pc_next_seq, pred_taken, pred_target
  );

  modport slave (
    input  stall, br_redirect, br_redirect_pc, jmp_redirect, jmp_redirect_pc,
           upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
    output pc, pc_next_seq, pred_taken, pred_target
  );
endinterface

// File: rtl/fetch_pc_predictor_btb_table.sv
// rtl/fetch_pc_predictor_btb_table.sv - direct-mapped tagged BTB with saturating direction counters
module btb_table
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = fetch_pc_predictor_pkg::WORD_SIZE,
  parameter int unsigned BTB_ENTRIES = fetch_pc_predictor_pkg::BTB_ENTRIES,
  parameter int unsigned CTR_BITS    = fetch_pc_predictor_pkg::CTR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 lookup_taken,
  output logic [WORD_SIZE-1:0] lookup_target,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target
);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = WORD_SIZE - IDX_W;
  localparam logic [CTR_BITS-1:0] C_MAX     = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] C_WEAK_NT = C_WEAK_T - 1'b1;

  typedef struct packed {
    logic                 valid;
    logic                 is_jump;
    logic [CTR_BITS-1:0]  ctr;
    logic [TAG_W-1:0]     tag;
    logic [WORD_SIZE-1:0] target;
  } entry_t;

  entry_t tbl [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  entry_t           rd_entry, wr_entry;
  logic             rd_hit, wr_hit;

  assign rd_idx   = lookup_pc[IDX_W-1:0];
  assign rd_tag   = lookup_pc[WORD_SIZE-1:IDX_W];
  assign wr_idx   = upd_pc[IDX_W-1:0];
  assign wr_tag   = upd_pc[WORD_SIZE-1:IDX_W];
  assign rd_entry = tbl[rd_idx];
  assign wr_entry = tbl[wr_idx];
  assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

  // Lookup reads the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    rd_hit        = rd_entry.valid && (rd_entry.tag == rd_tag);
    lookup_taken  = rd_hit && (rd_entry.is_jump || rd_entry.ctr[CTR_BITS-1]);
    lookup_target = rd_entry.target;
  end

  // Reset clears every entry and drops any concurrent update; otherwise apply the resolved outcome.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        tbl[i] <= '{valid: 1'b0, is_jump: 1'b0, ctr: C_WEAK_NT, tag: '0, target: '0};
      end
    end else if (upd_valid) begin
      if (upd_is_jump) begin
        tbl[wr_idx] <= '{valid: 1'b1, is_jump: 1'b1, ctr: C_MAX, tag: wr_tag, target: upd_target};
      end else if (upd_taken) begin
        if (wr_hit) begin
          tbl[wr_idx].target  <= upd_target;
          tbl[wr_idx].is_jump <= 1'b0;
          tbl[wr_idx].ctr     <= (wr_entry.ctr == C_MAX) ? wr_entry.ctr : wr_entry.ctr + 1'b1;
        end else begin
          tbl[wr_idx] <= '{valid: 1'b1, is_jump: 1'b0, ctr: C_WEAK_T, tag: wr_tag, target: upd_target};
        end
      end else if (wr_hit) begin
        tbl[wr_idx].ctr <= (wr_entry.ctr == '0) ? wr_entry.ctr : wr_entry.ctr - 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_pc_predictor.sv
// rtl/fetch_pc_predictor.sv - fetch PC register with redirect/stall/prediction next-PC selection
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int unsigned          WORD_SIZE   = fetch_pc_predictor_pkg::WORD_SIZE,
  parameter int unsigned          BTB_ENTRIES = fetch_pc_predictor_pkg::BTB_ENTRIES,
  parameter int unsigned          CTR_BITS    = fetch_pc_predictor_pkg::CTR_BITS,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fetch_pc_predictor_if.slave      bus
);
  logic [WORD_SIZE-1:0] pc_q;
  logic                 btb_taken;
  logic [WORD_SIZE-1:0] btb_target;

  btb_table #(
    .WORD_SIZE  (WORD_SIZE),
    .BTB_ENTRIES(BTB_ENTRIES),
    .CTR_BITS   (CTR_BITS)
  ) u_btb (
    .clk          (clk),
    .reset_n      (reset_n),
    .lookup_pc    (pc_q),
    .lookup_taken (btb_taken),
    .lookup_target(btb_target),
    .upd_valid    (bus.upd_valid),
    .upd_pc       (bus.upd_pc),
    .upd_is_jump  (bus.upd_is_jump),
    .upd_taken    (bus.upd_taken),
    .upd_target   (bus.upd_target)
  );

  // Prediction outputs follow the current PC combinationally.
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_next_seq = pc_q + 1'b1;
    bus.pred_taken  = btb_taken;
    bus.pred_target = btb_taken ? btb_target : bus.pc_next_seq;
  end

  // Older-stage corrections win over younger ones; redirects also override a stall.
  always_ff @(posedge clk) begin
    if (!reset_n)              pc_q <= RESET_PC;
    else if (bus.br_redirect)  pc_q <= bus.br_redirect_pc;
    else if (bus.jmp_redirect) pc_q <= bus.jmp_redirect_pc;
    else if (!bus.stall)       pc_q <= bus.pred_target;
  end
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// tb/tb_fetch_pc_predictor.sv - directed self-checking bench for fetch_pc_predictor
module tb_fetch_pc_predictor;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  fetch_pc_predictor_if #(.WORD_SIZE(16)) bus ();

  fetch_pc_predictor #(
    .WORD_SIZE(16), .BTB_ENTRIES(16), .CTR_BITS(2), .RESET_PC(16'h0010)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [15:0] p, input logic jump, input logic taken, input logic [15:0] tgt);
    bus.upd_valid = 1'b1; bus.upd_pc = p; bus.upd_is_jump = jump;
    bus.upd_taken = taken; bus.upd_target = tgt;
    step();
    bus.upd_valid = 1'b0;
  endtask

  task automatic goto(input logic [15:0] p);
    bus.br_redirect = 1'b1; bus.br_redirect_pc = p;
    step();
    bus.br_redirect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.stall = 0; bus.br_redirect = 0; bus.br_redirect_pc = '0;
    bus.jmp_redirect = 0; bus.jmp_redirect_pc = '0;
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_is_jump = 0; bus.upd_taken = 0; bus.upd_target = '0;
    step(); step();
    reset_n = 1'b1;

    chk("reset_pc", bus.pc, 32'h0010);
    chk("reset_pred_taken", bus.pred_taken, 32'h0);
    chk("reset_pred_target", bus.pred_target, 32'h0011);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("free_run_pc", bus.pc, 32'h0010 + i);
      chk("free_run_pred_taken", bus.pred_taken, 32'h0);
    end

    // Taken branch 0x0005 -> 0x0020, then weaken it twice.
    upd(16'h0005, 1'b0, 1'b1, 16'h0020);
    goto(16'h0005);
    chk("br_taken_pred", bus.pred_taken, 32'h1);
    chk("br_taken_target", bus.pred_target, 32'h0020);
    step();
    chk("br_taken_next_pc", bus.pc, 32'h0020);
    upd(16'h0005, 1'b0, 1'b0, 16'h0000);
    upd(16'h0005, 1'b0, 1'b0, 16'h0000);
    goto(16'h0005);
    chk("br_nt_pred", bus.pred_taken, 32'h0);
    chk("br_nt_target", bus.pred_target, 32'h0006);
    step();
    chk("br_nt_next_pc", bus.pc, 32'h0006);

    // Priority: branch redirect > jump redirect > stall.
    bus.br_redirect = 1; bus.br_redirect_pc = 16'h0040;
    bus.jmp_redirect = 1; bus.jmp_redirect_pc = 16'h0050; bus.stall = 1;
    step();
    chk("prio_br", bus.pc, 32'h0040);
    bus.br_redirect = 0;
    step();
    chk("prio_jmp_over_stall", bus.pc, 32'h0050);
    bus.jmp_redirect = 0;
    step();
    chk("stall_hold", bus.pc, 32'h0050);
    bus.stall = 0;

    // Aliasing on index 3: second allocation replaces the first.
    upd(16'h0003, 1'b0, 1'b1, 16'h0030);
    upd(16'h0013, 1'b0, 1'b1, 16'h0099);
    goto(16'h0003);
    chk("alias_miss_pred", bus.pred_taken, 32'h0);
    chk("alias_miss_target", bus.pred_target, 32'h0004);
    step();
    chk("alias_miss_next_pc", bus.pc, 32'h0004);
    goto(16'h0013);
    chk("alias_new_target", bus.pred_target, 32'h0099);

    // Saturation, with updates made during a stall.
    bus.stall = 1;
    for (int i = 0; i < 5; i++) upd(16'h0007, 1'b0, 1'b1, 16'h0070);
    upd(16'h0007, 1'b0, 1'b0, 16'h0000);
    chk("stall_during_upd", bus.pc, 32'h0013);
    bus.stall = 0;
    goto(16'h0007);
    chk("sat_still_taken", bus.pred_taken, 32'h1);
    bus.stall = 1;
    upd(16'h0007, 1'b0, 1'b0, 16'h0000);
    upd(16'h0007, 1'b0, 1'b0, 16'h0000);
    bus.stall = 0;
    goto(16'h0007);
    chk("sat_now_nt", bus.pred_taken, 32'h0);
    chk("sat_now_nt_target", bus.pred_target, 32'h0008);

    // Jump entry is taken even with upd_taken low.
    upd(16'h0009, 1'b1, 1'b0, 16'h0090);
    goto(16'h0009);
    chk("jump_pred", bus.pred_taken, 32'h1);
    chk("jump_target", bus.pred_target, 32'h0090);

    // PC wrap.
    goto(16'hFFFF);
    chk("wrap_seq", bus.pc_next_seq, 32'h0000);
    chk("wrap_pred", bus.pred_taken, 32'h0);
    step();
    chk("wrap_next_pc", bus.pc, 32'h0000);

    // Reset mid-run with a concurrent update: update discarded, table invalidated.
    reset_n = 1'b0;
    bus.br_redirect = 1; bus.br_redirect_pc = 16'h0077;
    upd(16'h0003, 1'b0, 1'b1, 16'h0033);
    bus.br_redirect = 0;
    reset_n = 1'b1;
    chk("mid_reset_pc", bus.pc, 32'h0010);
    goto(16'h0003);
    chk("mid_reset_upd_dropped", bus.pred_taken, 32'h0);
    goto(16'h0013);
    chk("mid_reset_alias_inval", bus.pred_taken, 32'h0);
    goto(16'h0009);
    chk("mid_reset_jump_inval", bus.pred_taken, 32'h0);
    chk("mid_reset_jump_target", bus.pred_target, 32'h000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
